// File: rtl/mult_test_sequencer_pkg.sv
// mult_test_pkg: state encoding and default sizing shared with the test control unit.
package mult_test_pkg;
    localparam int MTS_ADDR_WIDTH = 9;
    localparam int MTS_LATENCY    = 20;
    localparam int MTS_CNT_WIDTH  = 32;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mts_state_e;
endpackage

// File: rtl/mult_test_sequencer_if.sv
// mult_test_sequencer_if: control, operand-read and result-write signals of one test run.
interface mult_test_sequencer_if
    import mult_test_pkg::*;
#(
    parameter int ADDR_WIDTH = MTS_ADDR_WIDTH,
    parameter int CNT_WIDTH  = MTS_CNT_WIDTH
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  run_cycles;
    modport master (output start, abort, last_addr,
                    input  rd_en, rd_addr, wr_en, wr_addr, busy, done, run_cycles);
    modport slave  (input  start, abort, last_addr,
                    output rd_en, rd_addr, wr_en, wr_addr, busy, done, run_cycles);
endinterface

// File: rtl/mult_test_sequencer_delay_line.sv
// mts_delay_line: resettable {valid,data} shift register; any_valid_o flags entries
// still queued behind the one currently at the output.
module mts_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             any_valid_o
);
    localparam logic [DEPTH-1:0] PEND_MASK = {DEPTH{1'b1}} >> 1;
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= in_valid_i;
            d_q[0] <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end
    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign any_valid_o = |(v_q & PEND_MASK);
endmodule

// File: rtl/mult_test_sequencer.sv
// mult_test_sequencer: streams operand reads 0..last_addr and replays them LATENCY cycles
// later as result writes. Optional run-cycle counter enabled by MTS_CYCLE_COUNT_EN.
module mult_test_sequencer
    import mult_test_pkg::*;
#(
    parameter int ADDR_WIDTH = MTS_ADDR_WIDTH,
    parameter int LATENCY    = MTS_LATENCY,
    parameter int CNT_WIDTH  = MTS_CNT_WIDTH
) (
    input logic                  pll_clock,
    input logic                  resetn,
    mult_test_sequencer_if.slave bus
);
    mts_state_e            state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  any_valid;
    logic                  accept;
    logic                  busy;
    assign accept = (state_q == IDLE || state_q == DONE) && bus.start;
    assign busy   = state_q == ISSUE || state_q == DRAIN;
    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        last_d    = last_q;
        if (accept) begin
            state_d   = ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            last_d    = bus.last_addr;
        end else if (state_q == ISSUE) begin
            // Stop on the compare, never on a wrap, so a full sweep cannot reissue 0.
            if (bus.abort || rd_addr_q == last_q) begin
                state_d = DRAIN;
            end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end else if (state_q == DRAIN && !any_valid) begin
            state_d = DONE;
        end
    end
    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            last_q    <= last_d;
        end
    end
    mts_delay_line #(.WIDTH(ADDR_WIDTH), .DEPTH(LATENCY)) u_delay (
        .clk        (pll_clock),
        .rst_n      (resetn),
        .in_valid_i (rd_en_q),
        .in_data_i  (rd_addr_q),
        .out_valid_o(bus.wr_en),
        .out_data_o (bus.wr_addr),
        .any_valid_o(any_valid)
    );
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = busy;
    assign bus.done    = state_q == DONE;
`ifdef MTS_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    assign cnt_d = accept ? '0 : (busy && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign bus.run_cycles = cnt_q;
`else
    assign bus.run_cycles = '0;
`endif
endmodule

// File: tb/tb_mult_test_sequencer.sv
// tb_mult_test_sequencer: randomized runs checked against a cycle-index model of the run.
module tb_mult_test_sequencer;
    import mult_test_pkg::*;
    localparam int AW = MTS_ADDR_WIDTH;
    localparam int L  = MTS_LATENCY;
    logic pll_clock = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   errors  = 0;
    mult_test_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(MTS_CNT_WIDTH)) bus ();
    mult_test_sequencer #(.ADDR_WIDTH(AW), .LATENCY(L), .CNT_WIDTH(MTS_CNT_WIDTH)) dut (
        .pll_clock(pll_clock),
        .resetn   (resetn),
        .bus      (bus)
    );
    always #5 pll_clock = ~pll_clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_busy"},  bus.busy,  0);
        check({tag, "_done"},  bus.done,  0);
    endtask
    // Cycle c counts from 1 after the accepting edge: k reads in cycles 1..k,
    // writes in L+1..k+L, busy through k+L, done afterwards.
    task automatic run(input int last, input int abort_at, input bit start_with_abort);
        int n = last + 1;
        int k = (abort_at > 0 && abort_at < n) ? abort_at : n;
        @(negedge pll_clock);
        bus.start     = 1'b1;
        bus.abort     = start_with_abort;
        bus.last_addr = AW'(last);
        for (int c = 1; c <= k + L + 2; c++) begin
            @(negedge pll_clock);
            check("rd_en", bus.rd_en, c <= k);
            if (c <= k) check("rd_addr", bus.rd_addr, c - 1);
            check("wr_en", bus.wr_en, c > L && c <= k + L);
            if (c > L && c <= k + L) check("wr_addr", bus.wr_addr, c - 1 - L);
            check("busy", bus.busy, c <= k + L);
            check("done", bus.done, c > k + L);
`ifdef MTS_CYCLE_COUNT_EN
            check("run_cycles", bus.run_cycles, (c - 1 < k + L) ? c - 1 : k + L);
`else
            check("run_cycles", bus.run_cycles, 0);
`endif
            bus.start     = (c <= k + L) && ($urandom_range(7) == 0);
            bus.last_addr = AW'($urandom);
            bus.abort     = (c == abort_at) || (c > k && c <= k + L && $urandom_range(3) == 0);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask
    initial begin
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.last_addr = '0;
        repeat (3) @(negedge pll_clock);
        check_idle_outputs("reset");
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        check("reset_run_cycles", bus.run_cycles, 0);
        resetn = 1'b1;
        repeat (2) @(negedge pll_clock);
        check_idle_outputs("idle");
        run(7, 0, 1'b0);
        run(0, 0, 1'b0);
        run((1 << AW) - 1, 0, 1'b0);
        run(63, 5, 1'b0);
        run(15, 0, 1'b1);
        for (int r = 0; r < 8; r++)
            run($urandom_range(40), $urandom_range(0, 50), 1'($urandom_range(1)));
        // Reset in DRAIN with ten writes still in flight.
        @(negedge pll_clock);
        bus.start     = 1'b1;
        bus.last_addr = AW'(9);
        for (int c = 1; c <= 15; c++) begin
            @(negedge pll_clock);
            bus.start = 1'b0;
        end
        check("pre_reset_busy", bus.busy, 1);
        resetn = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        for (int c = 0; c < 25; c++) begin
            @(negedge pll_clock);
            check("in_reset_wr_en", bus.wr_en, 0);
        end
        resetn = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge pll_clock);
            check_idle_outputs("post_reset");
        end
        run(3, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
